// File: rtl/credit_input_buffer.sv
// Credit-based router input buffer: a DEPTH-entry circular FIFO that returns one
// credit pulse upstream for every flit the switch allocator pops.
module credit_input_buffer #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    input  logic              read_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              valid_o,
    output logic              credit_o,
    output logic [2:0]        count_o,
    output logic              overflow_o
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [2:0] LAST_C  = 3'(DEPTH - 1);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [2:0]        wr_ptr_q, wr_ptr_d;
    logic [2:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic              credit_q, credit_d;
    logic              overflow_q, overflow_d;
    logic              pop_acc, push_acc, push_drop;

    // Handshake: a pop is taken whenever read_i is high and the buffer holds a
    // flit; a push is taken whenever valid_i is high and there is room, where a
    // same-cycle pop frees a slot. There is no back-pressure towards upstream:
    // a push into a full buffer is dropped and flagged sticky in overflow_o.
    always_comb begin
        pop_acc   = read_i && (count_q != 3'd0);
        push_acc  = valid_i && ((count_q != DEPTH_C) || pop_acc);
        push_drop = valid_i && !push_acc;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = pop_acc;
        overflow_d = overflow_q | push_drop;
        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? 3'd0 : wr_ptr_q + 3'd1;
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? 3'd0 : rd_ptr_q + 3'd1;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= 3'd0;
            rd_ptr_q   <= 3'd0;
            count_q    <= 3'd0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; the rst term keeps a push that
    // coincides with an asserted reset from landing in the array.
    always_ff @(posedge clk) begin
        if (push_acc && rst) begin
            mem_q[wr_ptr_q] <= flit_i;
        end
    end

    always_comb begin
        valid_o    = (count_q != 3'd0);
        flit_o     = valid_o ? mem_q[rd_ptr_q] : '0;
        credit_o   = credit_q;
        count_o    = count_q;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_credit_input_buffer.sv
// Directed plus short random check of credit_input_buffer against a queue model
// of the FIFO contents, credit pulses and sticky overflow flag.
module tb_credit_input_buffer;

    localparam int FLIT_W = 32;
    localparam int DEPTH  = 5;

    logic              clk;
    logic              rst;
    logic [FLIT_W-1:0] flit_i;
    logic              valid_i;
    logic              read_i;
    logic [FLIT_W-1:0] flit_o;
    logic              valid_o;
    logic              credit_o;
    logic [2:0]        count_o;
    logic              overflow_o;

    logic [FLIT_W-1:0] exp_q[$];
    logic              ovf_m;
    int                total;
    int                bad;

    credit_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flit_i    (flit_i),
        .valid_i   (valid_i),
        .read_i    (read_i),
        .flit_o    (flit_o),
        .valid_o   (valid_o),
        .credit_o  (credit_o),
        .count_o   (count_o),
        .overflow_o(overflow_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; drives one cycle of stimulus, predicts the
    // result from the model, advances one edge and compares.
    task automatic cycle(input logic v, input logic [FLIT_W-1:0] f, input logic r);
        int   sz;
        logic pop_ok;
        logic push_ok;
        sz      = exp_q.size();
        pop_ok  = r && (sz != 0);
        push_ok = v && ((sz != DEPTH) || pop_ok);
        if (sz == 0) chk("flit_zero_when_empty", flit_o, 32'h0);
        if (pop_ok) chk("flit_head", flit_o, exp_q.pop_front());
        if (v && !push_ok) ovf_m = 1'b1;
        valid_i = v;
        flit_i  = f;
        read_i  = r;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        read_i  = 1'b0;
        flit_i  = '0;
        if (push_ok) exp_q.push_back(f);
        chk("count", 32'(count_o), 32'(exp_q.size()));
        chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
        chk("credit", 32'(credit_o), 32'(pop_ok));
        chk("overflow", 32'(overflow_o), 32'(ovf_m));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count_o), 32'h0);
        chk({tag, "_valid"}, 32'(valid_o), 32'h0);
        chk({tag, "_flit"}, flit_o, 32'h0);
        chk({tag, "_credit"}, 32'(credit_o), 32'h0);
        chk({tag, "_overflow"}, 32'(overflow_o), 32'h0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ovf_m   = 1'b0;
        valid_i = 1'b0;
        read_i  = 1'b0;
        flit_i  = '0;
        rst     = 1'b1;

        // Power-on reset, released mid-cycle.
        #2 rst = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single push is visible the next cycle.
        cycle(1'b1, 32'hA1, 1'b0);
        chk("a1_flit", flit_o, 32'hA1);
        cycle(1'b0, '0, 1'b1);

        // Pop on empty is ignored.
        cycle(1'b0, '0, 1'b1);

        // Fill then drain five flits in order with back-to-back credits.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Simultaneous push and pop on empty: push only, no credit.
        cycle(1'b1, 32'h3C, 1'b1);
        chk("3c_flit", flit_o, 32'h3C);
        cycle(1'b0, '0, 1'b1);

        // Full buffer with simultaneous push/pop keeps count and wraps pointers.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0);
        cycle(1'b1, 32'h66, 1'b1);
        chk("full_rw_count", 32'(count_o), 32'd5);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Push into a full buffer is dropped and latches overflow.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h20 + 32'(i), 1'b0);
        cycle(1'b1, 32'h77, 1'b0);
        chk("ovf_set", 32'(overflow_o), 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("ovf_sticky", 32'(overflow_o), 32'h1);

        // Asynchronous reset mid-cycle with flits queued and a credit pending.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h40 + 32'(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        #3 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        ovf_m   = 1'b0;
        valid_i = 1'b1;
        flit_i  = 32'h55;
        read_i  = 1'b1;
        @(posedge clk);
        #1 chk("push_in_reset_count", 32'(count_o), 32'h0);
        valid_i = 1'b0;
        read_i  = 1'b0;
        flit_i  = '0;
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Random traffic followed by a drain.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
